// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception/interrupt sequencer.
// Decides traps in M, latches SR/Cause/EPC, drives handler redirect.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h2018_1206
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic        Exc_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        eret_M,
    input  logic        CP0WE,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0WD,
    output logic [31:0] CP0RD,
    output logic        ExcReq,
    output logic [31:0] NPC_Exc,
    output logic [31:0] EPC_out,
    output logic        EXL
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_code;
    logic [31:0] r_epc;

    logic        w_exl;
    logic        w_int_req;
    logic        w_mtc0;
    logic [31:0] w_pc_base;
    logic [31:0] w_trap_epc;
    logic        w_unused;

    assign w_exl      = (r_state == HANDLER);
    assign w_int_req  = (|(HWInt & r_im)) & r_ie & ~w_exl;
    assign ExcReq     = w_int_req | Exc_M;
    assign w_mtc0     = CP0WE & ~ExcReq;
    assign w_pc_base  = {PC_M[31:2], 2'b00};
    assign w_trap_epc = BD_M ? (w_pc_base - 32'd4) : w_pc_base;
    assign w_unused   = ^PC_M[1:0];

    assign EXL     = w_exl;
    assign EPC_out = r_epc;
    assign NPC_Exc = ExcReq ? HANDLER_PC : r_epc;

    // Handler-mode state register (this is SR.EXL)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: trap enters, eret leaves, mtc0 SR may set EXL directly
    always_comb begin
        w_state_nxt = r_state;
        if (ExcReq) begin
            w_state_nxt = HANDLER;
        end else if (eret_M) begin
            w_state_nxt = RUN;
        end else if (w_mtc0 && (CP0Addr == 5'd12)) begin
            w_state_nxt = CP0WD[1] ? HANDLER : RUN;
        end
    end

    // SR/Cause/EPC updates; a trap cancels any mtc0 in M
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_im   <= 6'd0;
            r_ie   <= 1'b0;
            r_bd   <= 1'b0;
            r_ip   <= 6'd0;
            r_code <= 5'd0;
            r_epc  <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (ExcReq) begin
                r_code <= w_int_req ? 5'd0 : ExcCode_M;
                if (!w_exl) begin
                    r_bd  <= BD_M;
                    r_epc <= w_trap_epc;
                end
            end else if (w_mtc0) begin
                case (CP0Addr)
                    5'd12: begin
                        r_im <= CP0WD[15:10];
                        r_ie <= CP0WD[0];
                    end
                    5'd14: r_epc <= {CP0WD[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    // mfc0 read mux; unimplemented bits and registers read as zero
    always_comb begin
        CP0RD = 32'd0;
        case (CP0Addr)
            5'd12: CP0RD = {16'd0, r_im, 8'd0, w_exl, r_ie};
            5'd13: CP0RD = {r_bd, 15'd0, r_ip, 3'd0, r_code, 2'b00};
            5'd14: CP0RD = r_epc;
            5'd15: CP0RD = PRID;
            default: CP0RD = 32'd0;
        endcase
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 register file and exception/interrupt sequencer for the 5-stage MIPS pipeline.
- Takes the exception already detected and carried to M (Exc_M/ExcCode_M), the 6 hardware interrupt lines, and eret/mtc0 from M.
- Decides whether to take a trap, latches SR/Cause/EPC, and drives flush plus the handler-PC redirect.
- Tracks handler state (EXL) so that eret returns to EPC.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception entry address driven on NPC_Exc.
- PRID, 32'h2018_1206, read-only value of CP0 register 15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- PC_M  input  32  PC of the instruction in M. The pipeline carries a valid PC in bubbles.
- BD_M  input  1  instruction in M is in a branch delay slot.
- Exc_M  input  1  pipelined exception flag from exceptionF/D/E/M.
- ExcCode_M  input  5  code accompanying Exc_M.
- HWInt  input  6  hardware interrupt lines, level-sensitive.
- eret_M  input  1  eret in M.
- CP0WE  input  1  mtc0 write enable (in M).
- CP0Addr  input  5  mtc0/mfc0 register number.
- CP0WD  input  32  mtc0 write data.
- CP0RD  output  32  mfc0 read data, combinational.
- ExcReq  output  1  take trap this cycle; flush F..M and redirect.
- NPC_Exc  output  32  HANDLER_PC when ExcReq=1, else EPC.
- EPC_out  output  32  current EPC, used by eret redirect.
- EXL  output  1  handler mode flag.

Behaviour:
Registers
- SR (12): IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0. Not writable by mtc0.
- EPC (14): 32-bit, bits [1:0] forced to 0 on every write.
- PRId (15): returns PRID.
- Reads of any other address return 0.

Reset
- Asynchronous on reset_n=0: SR=0, Cause=0, EPC=0, FSM=RUN.
- Output values under reset: ExcReq=0, EXL=0, CP0RD=0 for all addresses except 15, EPC_out=0.

FSM
- Two states: RUN (EXL=0) and HANDLER (EXL=1).
- RUN -> HANDLER on ExcReq.
- HANDLER -> RUN on eret_M when ExcReq=0.
- Exc_M with EXL=1 stays in HANDLER.

Trap decision (combinational, same cycle)
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = IntReq | Exc_M.
- Interrupt has priority over Exc_M.

On the ExcReq rising edge
- If IntReq: ExcCode <= 0.
- Otherwise: ExcCode <= ExcCode_M.
- If EXL was 0:
  - BD <= BD_M.
  - EPC <= BD_M ? {PC_M[31:2],2'b0}-4 : {PC_M[31:2],2'b0}.
- If EXL was 1: EPC and BD hold.
- EXL <= 1 in all cases.

IP sampling
- Cause.IP <= HWInt every cycle, independent of masking and reset-free except by reset_n.

mtc0
- On a clk edge with CP0WE=1 and ExcReq=0: write SR (masked bits only) or EPC.
- Writes to 13 and 15 are ignored.

Simultaneous events
- ExcReq=1 blocks mtc0 (the M instruction is cancelled) and blocks eret.
- eret with mtc0 in the same cycle cannot occur (same stage); no priority is required.
- eret in RUN clears EXL (no-op) and redirects to EPC. The pipeline is responsible for legality.

Latency and timing
- ExcReq and NPC_Exc are combinational in the same cycle.
- Register updates are visible on CP0RD/EPC_out the cycle after the edge. No bypass.
- Reset mid-handler returns to RUN with IE=0, so interrupts stay masked until software sets SR.

Test Plan:
- Reset, then read 12/13/14/15 -> 0, 0, 0, 32'h2018_1206; ExcReq=0.
- Exc_M=1, ExcCode_M=5'd10, PC_M=32'h3010, BD_M=0 -> ExcReq=1, NPC_Exc=32'h4180; next cycle EPC=32'h3010, Cause[6:2]=10, EXL=1.
- Same as above with BD_M=1, PC_M=32'h3024 -> EPC=32'h3020, Cause[31]=1.
- mtc0 SR=32'h0000_FC01, then HWInt=6'b000100 -> ExcReq=1, ExcCode=0. With EXL=1, holding HWInt produces no second ExcReq.
- Second Exc_M (ExcCode 12) while EXL=1 -> ExcReq=1, ExcCode=12, EPC unchanged. Then eret_M -> EXL=0 next cycle, NPC_Exc=EPC.
- CP0WE to EPC, data 32'h3457, same cycle as Exc_M -> write dropped, EPC=PC_M. Async reset_n pulse mid-HANDLER -> EXL=0 immediately, without waiting for a clock edge.
